// File: rtl/jbus_pkg.sv
// Shared types, defaults and helpers for the jbus register-transfer sequencer.
package jbus_pkg;

  localparam int DEF_NREQ = 2;
  localparam int DEF_NREG = 4;
  localparam int DEF_IDXW = 2;

  // Widest register bank the sequencer supports (NREG <= 16).
  localparam int MAX_NREG = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENABLE = 2'd1,
    SET    = 2'd2,
    HOLD   = 2'd3
  } state_e;

  // Index to one-hot at full width; callers size-cast down to their bank width.
  function automatic logic [MAX_NREG-1:0] idx2oh(input logic [3:0] idx);
    idx2oh = MAX_NREG'(1) << idx;
  endfunction

endpackage

// File: rtl/jbus_rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping.
module jbus_rr_pick #(
  parameter int NREQ = 2,
  parameter int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PTRW-1:0] i_ptr,
  output logic            o_any,
  output logic [PTRW-1:0] o_winner,
  output logic [NREQ-1:0] o_winner_oh
);

  // Walk offsets from farthest to nearest so the nearest active requester is the last written.
  always_comb begin
    int idx;
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    o_any       = 1'b0;
    o_winner    = '0;
    o_winner_oh = '0;
    idx         = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(i_ptr) + i) % NREQ;
      if (i_req[idx]) begin
        o_any            = 1'b1;
        o_winner         = PTRW'(idx);
        o_winner_oh      = '0;
        o_winner_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jbus_sequencer.sv
// Bus arbiter turning granted transfer requests into register enable/set strobes.
// Optional build macro JBUS_SEQ_CHECK_EN adds the err output and src==dst rejection.
module jbus_sequencer
  import jbus_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int NREG = DEF_NREG,
  parameter int IDXW = DEF_IDXW
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*IDXW-1:0] src,
  input  logic [NREQ*IDXW-1:0] dst,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
`ifdef JBUS_SEQ_CHECK_EN
  output logic                 err,
`endif
  output logic [NREG-1:0]      reg_we,
  output logic [NREG-1:0]      reg_ws
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            r_state, w_state_nxt;
  logic [PTRW-1:0]   r_ptr, w_ptr_nxt;
  logic [IDXW-1:0]   r_src, w_src_nxt;
  logic [IDXW-1:0]   r_dst, w_dst_nxt;
  logic [NREQ-1:0]   r_gnt, w_gnt_nxt;
  logic [NREQ-1:0]   r_done, w_done_nxt;
  logic              r_busy;
  logic [NREG-1:0]   r_we, w_we_nxt;
  logic [NREG-1:0]   r_ws, w_ws_nxt;
`ifdef JBUS_SEQ_CHECK_EN
  logic              r_err, w_err_nxt;
`endif

  logic              w_any;
  logic [PTRW-1:0]   w_win;
  logic [NREQ-1:0]   w_win_oh;
  logic [IDXW-1:0]   w_sel_src;
  logic [IDXW-1:0]   w_sel_dst;
  logic [NREG-1:0]   w_sel_src_oh;
  logic [NREG-1:0]   w_r_src_oh;
  logic [NREG-1:0]   w_r_dst_oh;

  jbus_rr_pick #(.NREQ(NREQ), .PTRW(PTRW)) u_pick (
    .i_req       (req),
    .i_ptr       (r_ptr),
    .o_any       (w_any),
    .o_winner    (w_win),
    .o_winner_oh (w_win_oh)
  );

  always_comb begin
    w_sel_src = '0;
    w_sel_dst = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win_oh[i]) begin
        w_sel_src = src[i*IDXW +: IDXW];
        w_sel_dst = dst[i*IDXW +: IDXW];
      end
    end
  end

  assign w_sel_src_oh = NREG'(idx2oh(4'(w_sel_src)));
  assign w_r_src_oh   = NREG'(idx2oh(4'(r_src)));
  assign w_r_dst_oh   = NREG'(idx2oh(4'(r_dst)));

  // Outputs are computed for the state being entered, so they register alongside it.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_src_nxt   = r_src;
    w_dst_nxt   = r_dst;
    w_gnt_nxt   = r_gnt;
    w_we_nxt    = r_we;
    w_ws_nxt    = '0;
    w_done_nxt  = '0;
`ifdef JBUS_SEQ_CHECK_EN
    w_err_nxt   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_gnt_nxt = '0;
        w_we_nxt  = '0;
        if (w_any) begin
          w_src_nxt = w_sel_src;
          w_dst_nxt = w_sel_dst;
          w_gnt_nxt = w_win_oh;
          w_ptr_nxt = (w_win == PTRW'(NREQ - 1)) ? '0 : w_win + PTRW'(1);
`ifdef JBUS_SEQ_CHECK_EN
          if (w_sel_src == w_sel_dst) begin
            w_state_nxt = HOLD;
            w_done_nxt  = w_win_oh;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = ENABLE;
            w_we_nxt    = w_sel_src_oh;
          end
`else
          w_state_nxt = ENABLE;
          w_we_nxt    = w_sel_src_oh;
`endif
        end
      end
      ENABLE: begin
        w_state_nxt = SET;
        w_we_nxt    = w_r_src_oh;
        w_ws_nxt    = w_r_dst_oh;
      end
      SET: begin
        w_state_nxt = HOLD;
        w_done_nxt  = r_gnt;
      end
      HOLD: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_we_nxt    = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_we_nxt    = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_we    <= '0;
      r_ws    <= '0;
`ifdef JBUS_SEQ_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_src   <= w_src_nxt;
      r_dst   <= w_dst_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_we    <= w_we_nxt;
      r_ws    <= w_ws_nxt;
`ifdef JBUS_SEQ_CHECK_EN
      r_err   <= w_err_nxt;
`endif
    end
  end

  assign gnt    = r_gnt;
  assign done   = r_done;
  assign busy   = r_busy;
  assign reg_we = r_we;
  assign reg_ws = r_ws;
`ifdef JBUS_SEQ_CHECK_EN
  assign err    = r_err;
`endif

endmodule

// File: tb/tb_jbus_sequencer.sv
// Directed bench for jbus_sequencer (default build, NREQ=2, NREG=4, IDXW=2).
module tb_jbus_sequencer;

  logic       clk;
  logic       reset_n;
  logic [1:0] req;
  logic [3:0] src;
  logic [3:0] dst;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;
  logic [3:0] reg_we;
  logic [3:0] reg_ws;

  int n_total;
  int n_pass;

  jbus_sequencer #(.NREQ(2), .NREG(4), .IDXW(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .src     (src),
    .dst     (dst),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy),
    .reg_we  (reg_we),
    .reg_ws  (reg_ws)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [3:0] src;
    logic [3:0] dst;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic [3:0] we;
    logic [3:0] ws;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_outs(input string tag, input logic [1:0] e_gnt, input logic [1:0] e_done,
                            input logic e_busy, input logic [3:0] e_we, input logic [3:0] e_ws);
    check({tag, ".gnt"},    32'(gnt),    32'(e_gnt));
    check({tag, ".done"},   32'(done),   32'(e_done));
    check({tag, ".busy"},   32'(busy),   32'(e_busy));
    check({tag, ".reg_we"}, 32'(reg_we), 32'(e_we));
    check({tag, ".reg_ws"}, 32'(reg_ws), 32'(e_ws));
  endtask

  // Drive inputs, take one edge, sample 1 time unit later.
  task automatic step(input logic [1:0] r, input logic [3:0] s, input logic [3:0] d);
    req = r;
    src = s;
    dst = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req     = '0;
    src     = '0;
    dst     = '0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_outs("reset", 2'b00, 2'b00, 1'b0, 4'b0000, 4'b0000);
    reset_n = 1'b1;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step(vecs[i].req, vecs[i].src, vecs[i].dst);
      check_outs($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].done, vecs[i].busy,
                 vecs[i].we, vecs[i].ws);
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset_n = 1'b0;
    req     = '0;
    src     = '0;
    dst     = '0;

    // Single transfer: requester 0 moves register 2 -> 1.
    vecs[0]  = '{2'b01, 4'b0010, 4'b0001, 2'b01, 2'b00, 1'b1, 4'b0100, 4'b0000};
    vecs[1]  = '{2'b01, 4'b0010, 4'b0001, 2'b01, 2'b00, 1'b1, 4'b0100, 4'b0010};
    vecs[2]  = '{2'b01, 4'b0010, 4'b0001, 2'b01, 2'b01, 1'b1, 4'b0100, 4'b0000};
    vecs[3]  = '{2'b00, 4'b0010, 4'b0001, 2'b00, 2'b00, 1'b0, 4'b0000, 4'b0000};
    vecs[4]  = '{2'b00, 4'b0010, 4'b0001, 2'b00, 2'b00, 1'b0, 4'b0000, 4'b0000};
    // Contention: req0 moves 1 -> 0, req1 moves 3 -> 2, alternating from pointer 0.
    vecs[5]  = '{2'b11, 4'b1101, 4'b1000, 2'b01, 2'b00, 1'b1, 4'b0010, 4'b0000};
    vecs[6]  = '{2'b11, 4'b1101, 4'b1000, 2'b01, 2'b00, 1'b1, 4'b0010, 4'b0001};
    vecs[7]  = '{2'b11, 4'b1101, 4'b1000, 2'b01, 2'b01, 1'b1, 4'b0010, 4'b0000};
    vecs[8]  = '{2'b11, 4'b1101, 4'b1000, 2'b00, 2'b00, 1'b0, 4'b0000, 4'b0000};
    vecs[9]  = '{2'b11, 4'b1101, 4'b1000, 2'b10, 2'b00, 1'b1, 4'b1000, 4'b0000};
    vecs[10] = '{2'b11, 4'b1101, 4'b1000, 2'b10, 2'b00, 1'b1, 4'b1000, 4'b0100};
    vecs[11] = '{2'b11, 4'b1101, 4'b1000, 2'b10, 2'b10, 1'b1, 4'b1000, 4'b0000};
    vecs[12] = '{2'b11, 4'b1101, 4'b1000, 2'b00, 2'b00, 1'b0, 4'b0000, 4'b0000};
    vecs[13] = '{2'b11, 4'b1101, 4'b1000, 2'b01, 2'b00, 1'b1, 4'b0010, 4'b0000};
    vecs[14] = '{2'b11, 4'b1101, 4'b1000, 2'b01, 2'b00, 1'b1, 4'b0010, 4'b0001};
    vecs[15] = '{2'b11, 4'b1101, 4'b1000, 2'b01, 2'b01, 1'b1, 4'b0010, 4'b0000};
    vecs[16] = '{2'b11, 4'b1101, 4'b1000, 2'b00, 2'b00, 1'b0, 4'b0000, 4'b0000};
    vecs[17] = '{2'b11, 4'b1101, 4'b1000, 2'b10, 2'b00, 1'b1, 4'b1000, 4'b0000};

    do_reset();
    run_vecs(0, 4);
    do_reset();
    run_vecs(5, 17);

    // Late drop: requester 1 (1 -> 2) lets go of req during ENABLE.
    do_reset();
    step(2'b10, 4'b0100, 4'b1000);
    check_outs("drop_en", 2'b10, 2'b00, 1'b1, 4'b0010, 4'b0000);
    step(2'b00, 4'b0100, 4'b1000);
    check_outs("drop_set", 2'b10, 2'b00, 1'b1, 4'b0010, 4'b0100);
    step(2'b00, 4'b0100, 4'b1000);
    check_outs("drop_hold", 2'b10, 2'b10, 1'b1, 4'b0010, 4'b0000);
    step(2'b00, 4'b0100, 4'b1000);
    check_outs("drop_idle", 2'b00, 2'b00, 1'b0, 4'b0000, 4'b0000);

    // Input change: requester 0 latched 3 -> 0, then src/dst wander.
    do_reset();
    step(2'b01, 4'b0011, 4'b0000);
    check_outs("chg_en", 2'b01, 2'b00, 1'b1, 4'b1000, 4'b0000);
    step(2'b01, 4'b0001, 4'b0010);
    check_outs("chg_set", 2'b01, 2'b00, 1'b1, 4'b1000, 4'b0001);
    step(2'b01, 4'b0010, 4'b0001);
    check_outs("chg_hold", 2'b01, 2'b01, 1'b1, 4'b1000, 4'b0000);

    // Reset during SET aborts at once; pointer (1 after grant 0) must restart at 0.
    do_reset();
    step(2'b01, 4'b0010, 4'b0001);
    step(2'b01, 4'b0010, 4'b0001);
    check_outs("rst_pre", 2'b01, 2'b00, 1'b1, 4'b0100, 4'b0010);
    reset_n = 1'b0;
    #1;
    check_outs("rst_async", 2'b00, 2'b00, 1'b0, 4'b0000, 4'b0000);
    @(posedge clk);
    #1;
    check_outs("rst_nodone", 2'b00, 2'b00, 1'b0, 4'b0000, 4'b0000);
    reset_n = 1'b1;
    step(2'b11, 4'b1101, 4'b1000);
    check_outs("rst_ptr0", 2'b01, 2'b00, 1'b1, 4'b0010, 4'b0000);

    // Reset during SET, then lone requester 1 (0 -> 3).
    step(2'b11, 4'b1101, 4'b1000);
    reset_n = 1'b0;
    #1;
    check_outs("rst2_async", 2'b00, 2'b00, 1'b0, 4'b0000, 4'b0000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(2'b10, 4'b0000, 4'b1100);
    check_outs("rst2_gnt1", 2'b10, 2'b00, 1'b1, 4'b0001, 4'b0000);
    step(2'b10, 4'b0000, 4'b1100);
    check_outs("rst2_set", 2'b10, 2'b00, 1'b1, 4'b0001, 4'b1000);

    // src == dst without the check: sequence runs unchanged on register 3.
    do_reset();
    step(2'b01, 4'b0011, 4'b0011);
    check_outs("same_en", 2'b01, 2'b00, 1'b1, 4'b1000, 4'b0000);
    step(2'b01, 4'b0011, 4'b0011);
    check_outs("same_set", 2'b01, 2'b00, 1'b1, 4'b1000, 4'b1000);
    step(2'b00, 4'b0011, 4'b0011);
    check_outs("same_hold", 2'b01, 2'b01, 1'b1, 4'b1000, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
